counter_scheduler: RTL and testbench

- Time-shares one `counter` instance between N requesters. Each requester asks for an interval of `count_to` counts.
- Arbitration is round-robin. For the granted requester the block clears the counter, runs it to its terminal count, then returns a per-requester done pulse.
- Sits between requester logic and the `counter` ports `enable`, `srst`, `count_to` and `done`.

---
 rtl/counter_scheduler.sv | 175 +++++++++++++++++
 tb/tb_counter_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of a single counter among N requesters.
// Optional stuck-interval watchdog (adds wdog_err) is enabled by defining COUNTER_SCHED_WDOG_EN.
module counter_scheduler #(
  parameter int N = 4,
  parameter int W = 6,
  parameter logic [W-1:0] INIT_VAL = {W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*W-1:0]         req_count_to,
  output logic [N-1:0]           req_ready,
  output logic [N-1:0]           req_done,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   ctr_enable,
  output logic                   ctr_srst,
  output logic [W-1:0]           ctr_count_to,
  input  logic                   ctr_done
`ifdef COUNTER_SCHED_WDOG_EN
  ,
  output logic                   wdog_err
`endif
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic [W-1:0]    count_arr_s [N];

`ifdef COUNTER_SCHED_WDOG_EN
  localparam logic [W+1:0] WDOG_LAST = (W+2)'((1 << W) + 1);
  logic [W+1:0]    wdog_cnt_r;
`endif

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
    logic [IW-1:0] nxt;
    if (cur == IW'(N - 1)) begin
      nxt = {IW{1'b0}};
    end else begin
      nxt = cur + IW'(1);
    end
    return nxt;
  endfunction

  // Unpack the flat per-requester terminal counts.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      count_arr_s[i] = req_count_to[i*W +: W];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    sum          = {(IW+1){1'b0}};
    idx          = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end else begin
        sum = sum;
      end
      idx = sum[IW-1:0];
      if (!pick_found_s && req_valid[idx]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = idx;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Grant is offered only in IDLE and never while reset is applied.
  always_comb begin
    req_ready = {N{1'b0}};
    if (rst && (state_r == S_IDLE) && pick_found_s) begin
      req_ready = onehot(pick_idx_s);
    end else begin
      req_ready = {N{1'b0}};
    end
  end

  assign busy = (state_r != S_IDLE);

  // A zero-length interval never enables, independent of when ctr_done settles.
  assign ctr_enable = (state_r == S_RUN) && !ctr_done && (ctr_count_to != INIT_VAL);

  // Scheduler FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      rr_ptr_r     <= {IW{1'b0}};
      owner        <= {IW{1'b0}};
      ctr_count_to <= {W{1'b0}};
      ctr_srst     <= 1'b1;
      req_done     <= {N{1'b0}};
`ifdef COUNTER_SCHED_WDOG_EN
      wdog_cnt_r   <= {(W+2){1'b0}};
      wdog_err     <= 1'b0;
`endif
    end else begin
      req_done <= {N{1'b0}};
      ctr_srst <= 1'b0;
`ifdef COUNTER_SCHED_WDOG_EN
      wdog_err <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (pick_found_s) begin
            owner        <= pick_idx_s;
            ctr_count_to <= count_arr_s[pick_idx_s];
            ctr_srst     <= 1'b1;
            state_r      <= S_CLEAR;
          end else begin
            state_r      <= S_IDLE;
          end
        end
        S_CLEAR: begin
`ifdef COUNTER_SCHED_WDOG_EN
          wdog_cnt_r <= {(W+2){1'b0}};
`endif
          state_r <= S_RUN;
        end
        S_RUN: begin
          if (ctr_done) begin
            req_done <= onehot(owner);
            state_r  <= S_DONE;
`ifdef COUNTER_SCHED_WDOG_EN
          end else if (wdog_cnt_r == WDOG_LAST) begin
            wdog_err <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + (W+2)'(1);
            state_r    <= S_RUN;
          end
`else
          end else begin
            state_r  <= S_RUN;
          end
`endif
        end
        S_DONE: begin
          rr_ptr_r <= next_ptr(owner);
          state_r  <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler with a behavioural counter model.
module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_count_to;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_done;
  logic           busy;
  logic [1:0]     owner;
  logic           ctr_enable;
  logic           ctr_srst;
  logic [W-1:0]   ctr_count_to;
  logic           ctr_done;
  logic           tie_low = 1'b0;
`ifdef COUNTER_SCHED_WDOG_EN
  logic           wdog_err;
`endif

  int errors = 0;
  int checks = 0;
  int en_total = 0;
  logic [W-1:0] cnt = '0;

  counter_scheduler #(.N(N), .W(W), .INIT_VAL(6'd0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_count_to(req_count_to),
    .req_ready(req_ready), .req_done(req_done), .busy(busy), .owner(owner),
    .ctr_enable(ctr_enable), .ctr_srst(ctr_srst), .ctr_count_to(ctr_count_to),
    .ctr_done(ctr_done)
`ifdef COUNTER_SCHED_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  always #5 clk = ~clk;

  // Counter model: synchronous clear, increment on enable, done while count == count_to.
  always @(posedge clk) begin
    if (ctr_srst) cnt <= '0;
    else if (ctr_enable) cnt <= cnt + 6'd1;
    if (ctr_enable) en_total <= en_total + 1;
  end
  assign ctr_done = (cnt == ctr_count_to) && !tie_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_srst"}, ctr_srst, 1);
    chk({tag, "_en"}, ctr_enable, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_cto"}, ctr_count_to, 0);
  endtask

  // Full interval from the handshake cycle; caller has set req_valid/req_count_to.
  task automatic do_interval(input int exp_owner, input int k);
    int lat;
    int base;
    logic leak;
    logic [N-1:0] exp_oh;
    exp_oh = N'(1) << exp_owner;
    chk("grant", req_ready, exp_oh);
    chk("idle_busy", busy, 0);
    base = en_total;
    leak = 1'b0;
    tick();
    lat = 1;
    chk("clear_srst", ctr_srst, 1);
    chk("clear_en", ctr_enable, 0);
    chk("clear_cto", ctr_count_to, k);
    chk("clear_owner", owner, exp_owner);
    while (req_done == '0 && lat < 200) begin
      if (busy && req_ready != '0) leak = 1'b1;
      tick();
      lat++;
    end
    chk("done_latency", lat, k + 3);
    chk("done_onehot", req_done, exp_oh);
    chk("enable_count", en_total - base, k);
    chk("no_grant_busy", leak, 0);
    tick();
    chk("idle_after", busy, 0);
    chk("done_cleared", req_done, 0);
  endtask

  initial begin
    int base;
    int lat;
    logic seen;
    req_valid = '0;
    req_count_to = '0;

    // Reset, asserted asynchronously and held over clocks
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    tick();
    tick();
    chk_reset_outputs("rst_held");
    rst = 1'b1;
    tick();
    chk("post_rst_srst", ctr_srst, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", req_ready, 0);

    // Fairness: all valid, grants rotate 0,1,2,3,0
    req_count_to = {6'd9, 6'd7, 6'd5, 6'd3};
    req_valid = 4'hF;
    #1;
    do_interval(0, 3);
    do_interval(1, 5);
    do_interval(2, 7);
    do_interval(3, 9);
    do_interval(0, 3);

    // Single request, count_to=10
    req_valid = 4'b0010;
    req_count_to = {6'd0, 6'd0, 6'd10, 6'd0};
    #1;
    do_interval(1, 10);

    // Zero interval
    req_valid = 4'b0100;
    req_count_to = '0;
    #1;
    do_interval(2, 0);

    // Max interval
    req_valid = 4'b0001;
    req_count_to = {6'd0, 6'd0, 6'd0, 6'd63};
    #1;
    do_interval(0, 63);

    // Reset in the middle of RUN
    req_valid = 4'b1000;
    req_count_to = {6'd20, 6'd0, 6'd0, 6'd0};
    #1;
    chk("mid_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("mid_running_en", ctr_enable, 1);
    chk("mid_running_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    base = en_total;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (req_done != '0) seen = 1'b1;
    end
    chk("mid_no_done", seen, 0);
    chk("mid_no_enable", en_total - base, 0);
    rst = 1'b1;
    tick();
    req_valid = 4'hF;
    req_count_to = {6'd9, 6'd7, 6'd5, 6'd3};
    #1;
    do_interval(0, 3);

`ifdef COUNTER_SCHED_WDOG_EN
    // Watchdog: counter never reports done
    tie_low = 1'b1;
    #1;
    chk("wd_grant", req_ready, 4'b0010);
    base = en_total;
    seen = 1'b0;
    tick();
    lat = 1;
    while (wdog_err !== 1'b1 && lat < 200) begin
      if (req_done != '0) seen = 1'b1;
      tick();
      lat++;
    end
    chk("wd_latency", lat, 68);
    chk("wd_enables", en_total - base, 66);
    chk("wd_no_done", req_done, 0);
    chk("wd_no_done_run", seen, 0);
    tick();
    chk("wd_err_pulse", wdog_err, 0);
    chk("wd_idle", busy, 0);
    tie_low = 1'b0;
    #1;
    do_interval(2, 7);
`else
    lat = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
